// File: rtl/ssio_delay_cal_pkg.sv
// Shared types and helpers for the SDR input-delay calibration controller.
package ssio_delay_cal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StSample,
    StEval,
    StFinal
  } cal_state_e;

  // Width of a down-counter that is preset to n-1 and counts to zero.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefSampleCount  = 64;
  localparam int unsigned DefSettleCntW   = cnt_width(DefSettleCycles);
  localparam int unsigned DefSampleCntW   = cnt_width(DefSampleCount);

endpackage

// File: rtl/ssio_delay_cal_window.sv
// Tracks the current run of passing taps and the longest run seen so far.
// best_start_o/best_len_o include the evaluation presented this cycle, so the
// caller can act on the final tap's result in the same cycle.
module ssio_delay_cal_window #(
  parameter int unsigned TAP_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_i,
  input  logic                 eval_i,
  input  logic                 pass_i,
  input  logic [TAP_WIDTH-1:0] tap_i,
  output logic [TAP_WIDTH-1:0] best_start_o,
  output logic [TAP_WIDTH:0]   best_len_o
);

  localparam logic [TAP_WIDTH:0] LenOne = 1;

  logic [TAP_WIDTH-1:0] run_start_q, run_start_d;
  logic [TAP_WIDTH:0]   run_len_q, run_len_d;
  logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
  logic [TAP_WIDTH:0]   best_len_q, best_len_d;

  // Run/best update; strict greater-than keeps the earliest window on ties.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (init_i) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (eval_i) begin
      if (pass_i) begin
        if (run_len_q == '0) begin
          run_start_d = tap_i;
        end
        run_len_d = run_len_q + LenOne;
        if (run_len_d > best_len_q) begin
          best_len_d   = run_len_d;
          best_start_d = run_start_d;
        end
      end else begin
        run_len_d = '0;
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_d;
  assign best_len_o   = best_len_d;

endmodule

// File: rtl/ssio_delay_cal.sv
// Input-delay calibration controller: sweeps every tap, qualifies each against
// a fixed training word and loads the centre of the longest passing window.
module ssio_delay_cal
  import ssio_delay_cal_pkg::*;
#(
  parameter int unsigned       WIDTH         = 8,
  parameter int unsigned       TAP_WIDTH     = 5,
  parameter logic [WIDTH-1:0]  PATTERN       = 8'hA5,
  parameter int unsigned       SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned       SAMPLE_COUNT  = DefSampleCount
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     rx_d_i,
  output logic [TAP_WIDTH-1:0] delay_tap_o,
  output logic                 delay_load_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [TAP_WIDTH-1:0] window_lo_o,
  output logic [TAP_WIDTH-1:0] window_hi_o
);

  localparam int unsigned        SettleW  = cnt_width(SETTLE_CYCLES);
  localparam int unsigned        SampleW  = cnt_width(SAMPLE_COUNT);
  localparam logic [TAP_WIDTH-1:0] MaxTap = '1;
  localparam logic [TAP_WIDTH-1:0] TapOne = 1;
  localparam logic [TAP_WIDTH:0]   LenOne = 1;
  localparam logic [SettleW-1:0] SettlePreset = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [SampleW-1:0] SamplePreset = SampleW'(SAMPLE_COUNT - 1);
  localparam logic [SettleW-1:0] SettleOne    = 1;
  localparam logic [SampleW-1:0] SampleOne    = 1;

  cal_state_e state_q, state_d;

  logic [TAP_WIDTH-1:0] tap_q, tap_d;
  logic                 pass_q, pass_d;
  logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [SampleW-1:0]   sample_cnt_q, sample_cnt_d;

  logic [TAP_WIDTH-1:0] delay_tap_q, delay_tap_d;
  logic                 delay_load_q, delay_load_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic [TAP_WIDTH-1:0] win_lo_q, win_lo_d;
  logic [TAP_WIDTH-1:0] win_hi_q, win_hi_d;

  logic                 win_init;
  logic                 win_eval;
  logic [TAP_WIDTH-1:0] best_start;
  logic [TAP_WIDTH:0]   best_len;
  logic [TAP_WIDTH:0]   half_len;
  logic [TAP_WIDTH:0]   centre_sum;
  logic [TAP_WIDTH:0]   hi_sum;

  assign win_eval = (state_q == StEval);

  ssio_delay_cal_window #(
    .TAP_WIDTH(TAP_WIDTH)
  ) u_window (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_i      (win_init),
    .eval_i      (win_eval),
    .pass_i      (pass_q),
    .tap_i       (tap_q),
    .best_start_o(best_start),
    .best_len_o  (best_len)
  );

  // Floor centre and last tap of the selected window; only used when best_len is non-zero.
  always_comb begin
    half_len   = (best_len - LenOne) >> 1;
    centre_sum = {1'b0, best_start} + half_len;
    hi_sum     = {1'b0, best_start} + best_len - LenOne;
  end

  // Next-state and registered-output logic; outputs are computed one cycle
  // ahead so they are valid in the state they belong to.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    pass_d       = pass_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    delay_tap_d  = delay_tap_q;
    delay_load_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    locked_d     = locked_q;
    error_d      = error_q;
    win_lo_d     = win_lo_q;
    win_hi_d     = win_hi_q;
    win_init     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tap_d        = '0;
          locked_d     = 1'b0;
          error_d      = 1'b0;
          busy_d       = 1'b1;
          win_init     = 1'b1;
          delay_tap_d  = '0;
          delay_load_d = 1'b1;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        settle_cnt_d = SettlePreset;
        state_d      = StSettle;
      end
      StSettle: begin
        if (settle_cnt_q == '0) begin
          pass_d       = 1'b1;
          sample_cnt_d = SamplePreset;
          state_d      = StSample;
        end else begin
          settle_cnt_d = settle_cnt_q - SettleOne;
        end
      end
      StSample: begin
        if (rx_d_i != PATTERN) begin
          pass_d = 1'b0;
        end
        if (sample_cnt_q == '0) begin
          state_d = StEval;
        end else begin
          sample_cnt_d = sample_cnt_q - SampleOne;
        end
      end
      StEval: begin
        delay_load_d = 1'b1;
        // Check for the last tap before incrementing so tap never wraps.
        if (tap_q == MaxTap) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFinal;
          if (best_len == '0) begin
            error_d     = 1'b1;
            delay_tap_d = '0;
            win_lo_d    = '0;
            win_hi_d    = '0;
          end else begin
            locked_d    = 1'b1;
            delay_tap_d = centre_sum[TAP_WIDTH-1:0];
            win_lo_d    = best_start;
            win_hi_d    = hi_sum[TAP_WIDTH-1:0];
          end
        end else begin
          tap_d       = tap_q + TapOne;
          delay_tap_d = tap_q + TapOne;
          state_d     = StLoad;
        end
      end
      StFinal: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tap_q        <= '0;
      pass_q       <= 1'b0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      delay_tap_q  <= '0;
      delay_load_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      win_lo_q     <= '0;
      win_hi_q     <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      pass_q       <= pass_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      delay_tap_q  <= delay_tap_d;
      delay_load_q <= delay_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      win_lo_q     <= win_lo_d;
      win_hi_q     <= win_hi_d;
    end
  end

  assign delay_tap_o  = delay_tap_q;
  assign delay_load_o = delay_load_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign locked_o     = locked_q;
  assign error_o      = error_q;
  assign window_lo_o  = win_lo_q;
  assign window_hi_o  = win_hi_q;

endmodule

// File: tb/tb_ssio_delay_cal.sv
// Directed bench for ssio_delay_cal with default parameters and a simple
// link model that returns the training word only on passing taps.
module tb_ssio_delay_cal;

  localparam logic [7:0] PATTERN = 8'hA5;
  localparam int DONE_CYCLE = 2625;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic [4:0] delay_tap_o;
  logic       delay_load_o;
  logic       busy_o;
  logic       done_o;
  logic       locked_o;
  logic       error_o;
  logic [4:0] window_lo_o;
  logic [4:0] window_hi_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pass_mask = '0;
  int          corrupt_tap = -1;
  int          cur_tap = 0;
  int          since = 0;
  int          load_cnt = 0;

  ssio_delay_cal u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .rx_d_i      (rx_d),
    .delay_tap_o (delay_tap_o),
    .delay_load_o(delay_load_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .locked_o    (locked_o),
    .error_o     (error_o),
    .window_lo_o (window_lo_o),
    .window_hi_o (window_hi_o)
  );

  always #5 clk_i = ~clk_i;

  // Link model: the delay element latches the tap on delay_load; the word seen
  // for the following cycles depends on whether that tap is in the eye.
  always @(negedge clk_i) begin
    if (delay_load_o) begin
      cur_tap = int'(delay_tap_o);
      since = 0;
      load_cnt = load_cnt + 1;
    end else begin
      since = since + 1;
    end
    if (pass_mask[cur_tap] && !(cur_tap == corrupt_tap && since == 40)) rx_d = PATTERN;
    else rx_d = ~PATTERN;
  end

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Run one sweep; cycle 1 is the cycle after the edge that samples start.
  task automatic do_sweep(input logic [31:0] mask, input int ctap, input int extra,
                          output int done_cyc, output logic load_at_done,
                          output logic busy_mid, output int loads);
    int base;
    int cyc;
    pass_mask = mask;
    corrupt_tap = ctap;
    done_cyc = -1;
    load_at_done = 1'b0;
    busy_mid = 1'b0;
    @(negedge clk_i); #1;
    base = load_cnt;
    start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 4000) begin
      if (done_o) begin
        done_cyc = cyc;
        load_at_done = delay_load_o;
        break;
      end
      if (cyc == 100) busy_mid = busy_o;
      start_i = (cyc == extra);
      @(negedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    if (done_cyc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sweep_timeout: done not seen within %0d cycles", cyc);
    end
    @(negedge clk_i); #1;
    loads = load_cnt - base;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    #1;
    n_vec++;
    if ({delay_tap_o, delay_load_o, busy_o, done_o, locked_o, error_o, window_lo_o,
         window_hi_o} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got tap=%0d ld=%b busy=%b done=%b lk=%b err=%b lo=%0d hi=%0d want all 0",
               delay_tap_o, delay_load_o, busy_o, done_o, locked_o, error_o, window_lo_o,
               window_hi_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    n_vec++;
    if ({busy_o, delay_load_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: busy/ld/done=%b want 000", {busy_o, delay_load_o, done_o});
    end
  endtask

  task automatic test_single_window();
    int dc, loads;
    logic lad, bm;
    do_sweep(range_mask(10, 20), -1, -1, dc, lad, bm, loads);
    n_vec++;
    if (dc !== DONE_CYCLE) begin n_err++; $display("FAIL done_cycle: got %0d want %0d", dc, DONE_CYCLE); end
    n_vec++;
    if (lad !== 1'b1) begin n_err++; $display("FAIL final_load: got %b want 1", lad); end
    n_vec++;
    if (bm !== 1'b1) begin n_err++; $display("FAIL busy_mid: got %b want 1", bm); end
    n_vec++;
    if (loads !== 33) begin n_err++; $display("FAIL load_count: got %0d want 33", loads); end
    n_vec++;
    if ({locked_o, error_o} !== 2'b10) begin
      n_err++; $display("FAIL w10_flags: lk/err=%b want 10", {locked_o, error_o});
    end
    n_vec++;
    if (window_lo_o !== 5'd10 || window_hi_o !== 5'd20 || delay_tap_o !== 5'd15) begin
      n_err++;
      $display("FAIL w10_result: lo=%0d hi=%0d tap=%0d want 10 20 15", window_lo_o, window_hi_o,
               delay_tap_o);
    end
    n_vec++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_err++; $display("FAIL post_done: busy/done=%b want 00", {busy_o, done_o});
    end
  endtask

  task automatic test_two_windows();
    int dc, loads;
    logic lad, bm;
    do_sweep(range_mask(3, 5) | range_mask(20, 27), -1, -1, dc, lad, bm, loads);
    n_vec++;
    if (window_lo_o !== 5'd20 || window_hi_o !== 5'd27 || delay_tap_o !== 5'd23) begin
      n_err++;
      $display("FAIL longest_win: lo=%0d hi=%0d tap=%0d want 20 27 23", window_lo_o, window_hi_o,
               delay_tap_o);
    end
  endtask

  task automatic test_tie();
    int dc, loads;
    logic lad, bm;
    do_sweep(range_mask(2, 4) | range_mask(9, 11), -1, -1, dc, lad, bm, loads);
    n_vec++;
    if (window_lo_o !== 5'd2 || window_hi_o !== 5'd4 || delay_tap_o !== 5'd3) begin
      n_err++;
      $display("FAIL tie_win: lo=%0d hi=%0d tap=%0d want 2 4 3", window_lo_o, window_hi_o,
               delay_tap_o);
    end
  endtask

  task automatic test_no_pass();
    int dc, loads;
    logic lad, bm;
    do_sweep(32'h0, -1, -1, dc, lad, bm, loads);
    n_vec++;
    if ({locked_o, error_o} !== 2'b01) begin
      n_err++; $display("FAIL nopass_flags: lk/err=%b want 01", {locked_o, error_o});
    end
    n_vec++;
    if (delay_tap_o !== 5'd0 || window_lo_o !== 5'd0 || window_hi_o !== 5'd0) begin
      n_err++;
      $display("FAIL nopass_vals: tap=%0d lo=%0d hi=%0d want 0 0 0", delay_tap_o, window_lo_o,
               window_hi_o);
    end
    n_vec++;
    if (lad !== 1'b1) begin n_err++; $display("FAIL nopass_load: got %b want 1", lad); end
  endtask

  task automatic test_all_pass();
    int dc, loads;
    logic lad, bm;
    do_sweep(32'hFFFF_FFFF, -1, -1, dc, lad, bm, loads);
    n_vec++;
    if ({locked_o, error_o} !== 2'b10) begin
      n_err++; $display("FAIL allpass_flags: lk/err=%b want 10", {locked_o, error_o});
    end
    n_vec++;
    if (window_lo_o !== 5'd0 || window_hi_o !== 5'd31 || delay_tap_o !== 5'd15) begin
      n_err++;
      $display("FAIL allpass_win: lo=%0d hi=%0d tap=%0d want 0 31 15", window_lo_o, window_hi_o,
               delay_tap_o);
    end
  endtask

  task automatic test_corrupt_word();
    int dc, loads;
    logic lad, bm;
    do_sweep(range_mask(8, 15), 12, -1, dc, lad, bm, loads);
    n_vec++;
    if (window_lo_o !== 5'd8 || window_hi_o !== 5'd11 || delay_tap_o !== 5'd9) begin
      n_err++;
      $display("FAIL corrupt_win: lo=%0d hi=%0d tap=%0d want 8 11 9", window_lo_o, window_hi_o,
               delay_tap_o);
    end
  endtask

  task automatic test_back_to_back();
    int dc, loads;
    logic lad, bm;
    do_sweep(range_mask(10, 20), -1, 500, dc, lad, bm, loads);
    n_vec++;
    if (dc !== DONE_CYCLE) begin n_err++; $display("FAIL restart_cycle: got %0d want %0d", dc, DONE_CYCLE); end
    n_vec++;
    if (loads !== 33) begin n_err++; $display("FAIL restart_loads: got %0d want 33", loads); end
    n_vec++;
    if (delay_tap_o !== 5'd15 || locked_o !== 1'b1) begin
      n_err++; $display("FAIL restart_res: tap=%0d lk=%b want 15 1", delay_tap_o, locked_o);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int guard;
    int dc, loads;
    logic lad, bm;
    pass_mask = range_mask(10, 20);
    corrupt_tap = -1;
    @(negedge clk_i); #1;
    start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    guard = 0;
    while (!(cur_tap == 7 && since == 30) && guard < 2000) begin
      @(negedge clk_i); #1;
      guard++;
    end
    n_vec++;
    if (guard >= 2000) begin
      n_err++; $display("FAIL tap7_reach: cur_tap=%0d want 7", cur_tap);
    end
    #1 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({delay_tap_o, delay_load_o, busy_o, done_o, locked_o, error_o, window_lo_o,
         window_hi_o} !== 22'd0) begin
      n_err++;
      $display("FAIL async_reset: tap=%0d busy=%b lk=%b lo=%0d hi=%0d want all 0", delay_tap_o,
               busy_o, locked_o, window_lo_o, window_hi_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    dones = 0;
    repeat (100) begin
      @(negedge clk_i); #1;
      if (done_o) dones++;
    end
    n_vec++;
    if (dones !== 0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL no_done_after_rst: dones=%0d busy=%b want 0 0", dones, busy_o);
    end
    do_sweep(range_mask(10, 20), -1, -1, dc, lad, bm, loads);
    n_vec++;
    if (dc !== DONE_CYCLE || window_lo_o !== 5'd10 || window_hi_o !== 5'd20 ||
        delay_tap_o !== 5'd15) begin
      n_err++;
      $display("FAIL rerun: done_cyc=%0d lo=%0d hi=%0d tap=%0d want %0d 10 20 15", dc,
               window_lo_o, window_hi_o, delay_tap_o, DONE_CYCLE);
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_no_pass();
    test_two_windows();
    test_tie();
    test_all_pass();
    test_corrupt_word();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
